// File: rtl/aes128_dec_key_sequencer.sv
// AES-128 key expansion into an 11-slot round-key table, then serves the
// keys in decryption order (slot 10 down to slot 0) to an iterative core.
module aes128_dec_key_sequencer #(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Key_Load,
  input  logic [BLOCK_LENGTH-1:0] Cipher_Key,
  input  logic                    Start,
  output logic                    Ready,
  output logic                    En,
  output logic [BLOCK_LENGTH-1:0] RoundKey_o,
  output logic [3:0]              Round_Number,
  output logic                    Done
);

  typedef enum logic [1:0] {
    S_EMPTY, S_EXPAND, S_READY, S_RUN
  } state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    unique case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    en_q, en_d;
  logic                    done_q, done_d;
  logic [3:0]              rnd_q, rnd_d;
  logic [BLOCK_LENGTH-1:0] rk_q, rk_d;
  logic [BLOCK_LENGTH-1:0] key_q [11];

  logic                    wr_en;
  logic [3:0]              wr_idx;
  logic [BLOCK_LENGTH-1:0] wr_data;

  logic [3:0]   prv;
  logic [127:0] prev;
  logic [31:0]  rot, temp, n0, n1, n2, n3;
  logic [127:0] nxt_key;

  // One key-schedule step from the previous slot
  always_comb begin
    prv  = cnt_q - 4'd1;
    prev = key_q[prv];
    rot  = {prev[23:0], prev[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]),
            sbox(rot[15:8]), sbox(rot[7:0])}
           ^ {rcon(cnt_q), 24'h0};
    n0 = prev[127:96] ^ temp;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    nxt_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rnd_d   = rnd_q;
    rk_d    = rk_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    wr_data = nxt_key;
    if (Key_Load) begin
      state_d = S_EXPAND;
      cnt_d   = 4'd1;
      en_d    = 1'b0;
      rnd_d   = 4'd0;
      wr_en   = 1'b1;
      wr_idx  = 4'd0;
      wr_data = Cipher_Key;
    end else begin
      unique case (state_q)
        S_EXPAND: begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd10) state_d = S_READY;
        end
        S_READY: begin
          if (Start) begin
            state_d = S_RUN;
            en_d    = 1'b1;
            rnd_d   = 4'd0;
            rk_d    = key_q[10];
          end
        end
        S_RUN: begin
          if (rnd_q == 4'd10) begin
            state_d = S_READY;
            en_d    = 1'b0;
            rnd_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            rnd_d = rnd_q + 4'd1;
            rk_d  = key_q[4'd9 - rnd_q];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_EMPTY;
      cnt_q   <= 4'd0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      rnd_q   <= 4'd0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
      rnd_q   <= rnd_d;
      rk_q    <= rk_d;
    end
  end

  // Table is not cleared by reset; it is rebuilt on every key load
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) key_q[wr_idx] <= wr_data;
  end

  assign Ready        = (state_q == S_READY);
  assign En           = en_q;
  assign Done         = done_q;
  assign Round_Number = rnd_q;
  assign RoundKey_o   = rk_q;

endmodule

// File: tb/tb_aes128_dec_key_sequencer.sv
// Directed bench for aes128_dec_key_sequencer using FIPS-197 key schedules.
// Outputs are sampled 1 time unit after each rising edge.
module tb_aes128_dec_key_sequencer;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Key_Load;
  logic [127:0] Cipher_Key;
  logic         Start;
  logic         Ready;
  logic         En;
  logic [127:0] RoundKey_o;
  logic [3:0]   Round_Number;
  logic         Done;

  int checks = 0;
  int failures = 0;

  logic [127:0] ka [11];
  logic [127:0] kb0, kb10;

  aes128_dec_key_sequencer #(.BLOCK_LENGTH(128)) dut (
    .CLK(CLK),
    .RST(RST),
    .Key_Load(Key_Load),
    .Cipher_Key(Cipher_Key),
    .Start(Start),
    .Ready(Ready),
    .En(En),
    .RoundKey_o(RoundKey_o),
    .Round_Number(Round_Number),
    .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_a(input string tag);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      chk({tag, "_en"}, En, 1'b1);
      chk({tag, "_rdy"}, Ready, 1'b0);
      chk({tag, "_rnd"}, Round_Number, k[3:0]);
      chk({tag, "_key"}, RoundKey_o, ka[10-k]);
    end
    tick();
    chk({tag, "_end_en"}, En, 1'b0);
    chk({tag, "_end_done"}, Done, 1'b1);
    chk({tag, "_end_rdy"}, Ready, 1'b1);
    chk({tag, "_end_rnd"}, Round_Number, 4'd0);
  endtask

  initial begin
    ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
    ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kb0    = 128'h000102030405060708090a0b0c0d0e0f;
    kb10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    RST = 1'b1;
    Key_Load = 1'b0;
    Start = 1'b0;
    Cipher_Key = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_rdy", Ready, 1'b0);
    chk("rst_en", En, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_rnd", Round_Number, 4'd0);
    chk("rst_key", RoundKey_o, 128'h0);

    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("empty_start_en", En, 1'b0);
    chk("empty_start_rdy", Ready, 1'b0);

    Cipher_Key = ka[0];
    Key_Load = 1'b1;
    tick();
    Key_Load = 1'b0;
    chk("ldA_t0_rdy", Ready, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      if (i == 2) Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("ldA_exp_rdy", Ready, 1'b0);
      chk("ldA_exp_en", En, 1'b0);
    end
    tick();
    chk("ldA_t10_rdy", Ready, 1'b1);
    chk("ldA_t10_en", En, 1'b0);

    run_a("runA");
    run_a("b2b");
    chk("hold_key", RoundKey_o, ka[0]);
    tick();
    chk("b2b_done_low", Done, 1'b0);
    chk("b2b_rdy", Ready, 1'b1);

    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("ab_rnd5", Round_Number, 4'd5);
    Cipher_Key = kb0;
    Key_Load = 1'b1;
    tick();
    Key_Load = 1'b0;
    chk("ab_en", En, 1'b0);
    chk("ab_rnd", Round_Number, 4'd0);
    chk("ab_done", Done, 1'b0);
    chk("ab_rdy", Ready, 1'b0);
    chk("ab_hold_key", RoundKey_o, ka[5]);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("ab_exp_done", Done, 1'b0);
      chk("ab_exp_rdy", Ready, 1'b0);
    end
    tick();
    chk("ab_t10_rdy", Ready, 1'b1);
    chk("ab_t10_done", Done, 1'b0);

    Start = 1'b1;
    Key_Load = 1'b1;
    tick();
    Start = 1'b0;
    Key_Load = 1'b0;
    chk("sk_en", En, 1'b0);
    chk("sk_rdy", Ready, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("sk_exp_en", En, 1'b0);
    end
    tick();
    chk("sk_t10_rdy", Ready, 1'b1);

    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("runB_r0_en", En, 1'b1);
    chk("runB_r0_rnd", Round_Number, 4'd0);
    chk("runB_r0_key", RoundKey_o, kb10);
    for (int k = 1; k <= 10; k++) tick();
    chk("runB_r10_rnd", Round_Number, 4'd10);
    chk("runB_r10_key", RoundKey_o, kb0);
    tick();
    chk("runB_done", Done, 1'b1);
    chk("runB_end_en", En, 1'b0);

    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    chk("mr_en_before", En, 1'b1);
    RST = 1'b1;
    tick();
    chk("mr1_en", En, 1'b0);
    chk("mr1_rdy", Ready, 1'b0);
    chk("mr1_done", Done, 1'b0);
    chk("mr1_rnd", Round_Number, 4'd0);
    tick();
    RST = 1'b0;
    chk("mr2_en", En, 1'b0);
    chk("mr2_rdy", Ready, 1'b0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("mr_start_en", En, 1'b0);
    chk("mr_start_rdy", Ready, 1'b0);

    Cipher_Key = ka[0];
    Key_Load = 1'b1;
    tick();
    Key_Load = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    chk("reld_rdy", Ready, 1'b1);
    run_a("runA2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
